maxi_rd_arbiter: RTL

MAXI_RD_ARBITER -- requirements
Module: maxi_rd_arbiter

---
 rtl/maxi_rd_arb_pkg.sv | 18 +
 rtl/maxi_rd_arb_cnt.sv | 41 ++++
 rtl/maxi_rd_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/maxi_rd_arb_pkg.sv
// maxi_rd_arb_pkg
//   Shared constants and types for the two-requester AXI read-address arbiter.
//   No ports. Imported by maxi_rd_arb_cnt and maxi_rd_arbiter.
package maxi_rd_arb_pkg;
   localparam int NUM_REQ    = 2;
   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 64;
   localparam int AXI_LEN_W  = 8;
   localparam int CNT_W      = 4;   // holds MAX_OUTSTANDING up to 15

   localparam logic [2:0] ARSIZE_8B  = 3'b011;
   localparam logic [1:0] BURST_INCR = 2'b01;

   typedef enum logic {
      IDLE = 1'b0,
      ADDR = 1'b1
   } arb_state_e;
endpackage

// File: rtl/maxi_rd_arb_cnt.sv
// maxi_rd_arb_cnt
//   Outstanding-burst counter for one requester.
//   Ports:
//     ACLK, ARESET   clock, async active-high reset
//     inc            AR handshake for this requester
//     dec            last R beat handshaken for this requester
//     count          bursts accepted but not yet completed
//     at_max         count has reached MAX_OUTSTANDING (requester ineligible)
//     underflow_err  last R beat arrived while nothing was outstanding
module maxi_rd_arb_cnt
   import maxi_rd_arb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             at_max,
   output logic             underflow_err
);

   logic dec_ok;

   // A completion with nothing outstanding is discarded (count stays put)
   // and flagged; it can never cancel a same-cycle increment.
   assign underflow_err = dec && (count == '0);
   assign dec_ok        = dec && !underflow_err;
   assign at_max        = (count >= CNT_W'(MAX_OUTSTANDING));

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)
         count <= '0;
      else if (inc && !dec_ok)
         count <= count + 1'b1;
      else if (dec_ok && !inc)
         count <= count - 1'b1;
   end

endmodule

// File: rtl/maxi_rd_arbiter.sv
// maxi_rd_arbiter
//   Arbitrates two AXI read requesters onto one master read port. The AR
//   channel is registered (one grant per two cycles at best); the R channel is
//   routed back combinationally by RID with zero latency.
//   Ports:
//     ACLK, ARESET                    clock, async active-high reset
//     sN_ar_valid/ready/addr/len      requester N read-address handshake
//     sN_r_valid/ready/data/resp/last requester N read-data handshake
//     M_AXI_AR*                       master read-address channel (ARID = requester)
//     M_AXI_R*                        master read-data channel
//     err_out                         sticky: last R beat with nothing outstanding
//   Build option:
//     MAXI_RD_ARB_RR_EN  defined   -> round-robin, tie goes to the requester not
//                                     granted last (the normal build)
//                        undefined -> fixed priority, requester 0 wins ties
module maxi_rd_arbiter
   import maxi_rd_arb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  s0_ar_valid,
   output logic                  s0_ar_ready,
   input  logic [AXI_ADDR_W-1:0] s0_ar_addr,
   input  logic [AXI_LEN_W-1:0]  s0_ar_len,
   output logic                  s0_r_valid,
   input  logic                  s0_r_ready,
   output logic [AXI_DATA_W-1:0] s0_r_data,
   output logic [1:0]            s0_r_resp,
   output logic                  s0_r_last,
   input  logic                  s1_ar_valid,
   output logic                  s1_ar_ready,
   input  logic [AXI_ADDR_W-1:0] s1_ar_addr,
   input  logic [AXI_LEN_W-1:0]  s1_ar_len,
   output logic                  s1_r_valid,
   input  logic                  s1_r_ready,
   output logic [AXI_DATA_W-1:0] s1_r_data,
   output logic [1:0]            s1_r_resp,
   output logic                  s1_r_last,
   output logic                  M_AXI_ARID,
   output logic [AXI_ADDR_W-1:0] M_AXI_ARADDR,
   output logic [AXI_LEN_W-1:0]  M_AXI_ARLEN,
   output logic [2:0]            M_AXI_ARSIZE,
   output logic [1:0]            M_AXI_ARBURST,
   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   input  logic                  M_AXI_RID,
   input  logic [AXI_DATA_W-1:0] M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RLAST,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY,
   output logic                  err_out
);

   arb_state_e            state, state_nxt;
   logic                  ar_id, ar_id_nxt;
   logic [AXI_ADDR_W-1:0] ar_addr, ar_addr_nxt;
   logic [AXI_LEN_W-1:0]  ar_len, ar_len_nxt;
   logic [NUM_REQ-1:0]    req_vld, elig, at_max, inc, dec, uflow;
   logic                  win, ar_hs, r_hs;

   assign req_vld = {s1_ar_valid, s0_ar_valid};
   assign elig    = req_vld & ~at_max;
   assign ar_hs   = (state == ADDR) && M_AXI_ARREADY;
   assign r_hs    = M_AXI_RVALID && M_AXI_RREADY;

`ifdef MAXI_RD_ARB_RR_EN
   // rr_ptr names the requester that wins the next tie; it moves past the
   // winner only when the master actually accepts the address.
   logic rr_ptr;

   assign win = (&elig) ? rr_ptr : elig[1];

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)
         rr_ptr <= 1'b0;
      else if (ar_hs)
         rr_ptr <= ~ar_id;
   end
`else
   assign win = !elig[0];
`endif

   always_comb begin
      state_nxt   = state;
      ar_id_nxt   = ar_id;
      ar_addr_nxt = ar_addr;
      ar_len_nxt  = ar_len;
      case (state)
         IDLE: begin
            if (|elig) begin
               state_nxt   = ADDR;
               ar_id_nxt   = win;
               ar_addr_nxt = win ? s1_ar_addr : s0_ar_addr;
               ar_len_nxt  = win ? s1_ar_len  : s0_ar_len;
            end
         end
         ADDR: begin
            // Hold everything stable until the master takes it.
            if (M_AXI_ARREADY)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state   <= IDLE;
         ar_id   <= 1'b0;
         ar_addr <= '0;
         ar_len  <= '0;
      end else begin
         state   <= state_nxt;
         ar_id   <= ar_id_nxt;
         ar_addr <= ar_addr_nxt;
         ar_len  <= ar_len_nxt;
      end
   end

   generate
      for (genvar n = 0; n < NUM_REQ; n++) begin : g_req
         assign inc[n] = ar_hs && (ar_id == 1'(n));
         assign dec[n] = r_hs && M_AXI_RLAST && (M_AXI_RID == 1'(n));

         maxi_rd_arb_cnt #(
            .MAX_OUTSTANDING(MAX_OUTSTANDING)
         ) u_cnt (
            .ACLK          (ACLK),
            .ARESET        (ARESET),
            .inc           (inc[n]),
            .dec           (dec[n]),
            .count         (),
            .at_max        (at_max[n]),
            .underflow_err (uflow[n])
         );
      end
   endgenerate

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)
         err_out <= 1'b0;
      else if (|uflow)
         err_out <= 1'b1;
   end

   assign M_AXI_ARVALID = (state == ADDR);
   assign M_AXI_ARID    = ar_id;
   assign M_AXI_ARADDR  = ar_addr;
   assign M_AXI_ARLEN   = ar_len;
   assign M_AXI_ARSIZE  = ARSIZE_8B;
   assign M_AXI_ARBURST = BURST_INCR;

   assign s0_ar_ready = ar_hs && !ar_id;
   assign s1_ar_ready = ar_hs &&  ar_id;

   assign s0_r_valid   = M_AXI_RVALID && !M_AXI_RID;
   assign s1_r_valid   = M_AXI_RVALID &&  M_AXI_RID;
   assign s0_r_data    = M_AXI_RDATA;
   assign s1_r_data    = M_AXI_RDATA;
   assign s0_r_resp    = M_AXI_RRESP;
   assign s1_r_resp    = M_AXI_RRESP;
   assign s0_r_last    = M_AXI_RLAST;
   assign s1_r_last    = M_AXI_RLAST;
   assign M_AXI_RREADY = M_AXI_RID ? s1_r_ready : s0_r_ready;

endmodule
